// File: rtl/prog_clk_div.sv
// prog_clk_div: run-time programmable integer clock divider with a load/busy handshake.
// New ratios take effect only at an output-period boundary, so no phase is ever cut short.
`default_nettype none

module prog_clk_div #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
    output logic             clk_out,
    output logic             rise_stb,
    output logic [CNT_W-1:0] cur_div
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(DEFAULT_DIV - 1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow;

    logic             wrap;
    logic             apply;
    logic             load_ok;
    logic             load_bad;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] period_n;
    logic [CNT_W:0]   high_len;

    always_comb begin
        wrap     = (cnt == (cur_div - ONE));
        apply    = wrap && (state == PEND);
        load_ok  = div_load && (div_val >= MIN_DIV);
        load_bad = div_load && (div_val <  MIN_DIV);
        cnt_next = wrap ? '0 : (cnt + ONE);
        // The edge that adopts a new ratio already shapes its first high phase.
        period_n = apply ? shadow : cur_div;
        // One extra bit keeps ceil(N/2) exact at the maximum ratio.
        high_len = ({1'b0, period_n} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            cnt      <= RST_CNT;
            cur_div  <= RST_DIV;
            shadow   <= RST_DIV;
            clk_out  <= 1'b0;
            rise_stb <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            clk_out  <= ({1'b0, cnt_next} < high_len);
            rise_stb <= (cnt_next == '0);
            div_err  <= load_bad;

            case (state)
                RUN: begin
                    if (load_ok) begin
                        shadow <= div_val;
                        state  <= PEND;
                    end
                end
                PEND: begin
                    if (apply) begin
                        cur_div <= shadow;
                        state   <= RUN;
                    end
                    // A legal load on the boundary edge queues for the next boundary.
                    if (load_ok) begin
                        shadow <= div_val;
                        state  <= PEND;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign div_busy = (state == PEND);

endmodule

`default_nettype wire

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: directed vector table plus randomized loads checked against a
// period-queue reference model of prog_clk_div.
`default_nettype none

module tb_prog_clk_div;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clk_in;
    logic             reset_n;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             div_busy;
    logic             div_err;
    logic             clk_out;
    logic             rise_stb;
    logic [CNT_W-1:0] cur_div;

    prog_clk_div #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .div_val  (div_val),
        .div_load (div_load),
        .div_busy (div_busy),
        .div_err  (div_err),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .cur_div  (cur_div)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: each period is expanded into a queue of {clk,rise} samples.
    logic [1:0] per_q[$];
    int         m_n;
    bit         m_pend;
    int         m_pend_val;
    bit         m_clk, m_rise, m_err;

    task automatic model_reset();
        per_q.delete();
        m_n        = DEFAULT_DIV;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_clk      = 1'b0;
        m_rise     = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_edge(input bit load, input int val);
        logic [1:0] e;
        if (per_q.size() == 0) begin
            if (m_pend) begin
                m_n    = m_pend_val;
                m_pend = 1'b0;
            end
            for (int i = 0; i < m_n; i++)
                per_q.push_back({(i < (m_n + 1) / 2), (i == 0)});
        end
        e      = per_q.pop_front();
        m_clk  = e[1];
        m_rise = e[0];
        m_err  = load && (val < 2);
        if (load && val >= 2) begin
            m_pend     = 1'b1;
            m_pend_val = val;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("clk_out",  int'(clk_out),  int'(m_clk));
        chk("rise_stb", int'(rise_stb), int'(m_rise));
        chk("div_err",  int'(div_err),  int'(m_err));
        chk("div_busy", int'(div_busy), int'(m_pend));
        chk("cur_div",  int'(cur_div),  m_n);
    endtask

    // One clk_in edge with the given load request; outputs sampled 1ns later.
    task automatic step(input bit load, input int val);
        div_load = load;
        div_val  = CNT_W'(val);
        @(posedge clk_in);
        #1;
        model_edge(load, val);
        div_load = 1'b0;
    endtask

    task automatic step_chk(input bit load, input int val);
        step(load, val);
        chk_model();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_clk_out",  int'(clk_out),  0);
        chk("rst_rise_stb", int'(rise_stb), 0);
        chk("rst_div_busy", int'(div_busy), 0);
        chk("rst_div_err",  int'(div_err),  0);
        chk("rst_cur_div",  int'(cur_div),  DEFAULT_DIV);
        model_reset();
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit load;
        int val;
        bit clk;
        bit rise;
        int cur;
        bit busy;
        bit err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Reset release, default /4, then N=6 loaded one cycle after a strobe.
        tbl[0]  = '{0, 0, 1, 1, 4, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 4, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 4, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 4, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 4, 0, 0};
        tbl[5]  = '{1, 6, 1, 0, 4, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 4, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 4, 1, 0};
        tbl[8]  = '{0, 0, 1, 1, 6, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 6, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 6, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 6, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 6, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 6, 0, 0};
        tbl[14] = '{0, 0, 1, 1, 6, 0, 0};

        reset_n  = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        model_reset();
        #12;
        apply_reset();

        foreach (tbl[i]) begin
            step(tbl[i].load, tbl[i].val);
            chk($sformatf("tbl%0d_clk_out", i),  int'(clk_out),  int'(tbl[i].clk));
            chk($sformatf("tbl%0d_rise_stb", i), int'(rise_stb), int'(tbl[i].rise));
            chk($sformatf("tbl%0d_cur_div", i),  int'(cur_div),  tbl[i].cur);
            chk($sformatf("tbl%0d_div_busy", i), int'(div_busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_div_err", i),  int'(div_err),  int'(tbl[i].err));
        end

        // N=5: 3 high, 2 low after the boundary.
        step_chk(1, 5);
        for (int i = 0; i < 16; i++) step_chk(0, 0);

        // Illegal ratios pulse div_err and change nothing else.
        step_chk(1, 1);
        chk("err_n1", int'(div_err), 1);
        step_chk(0, 0);
        chk("err_n1_clear", int'(div_err), 0);
        step_chk(1, 0);
        chk("err_n0", int'(div_err), 1);
        chk("err_n0_cur", int'(cur_div), 5);
        for (int i = 0; i < 6; i++) step_chk(0, 0);

        // Overwrite a pending 6 with 3 before the boundary; 6 never appears.
        step_chk(1, 6);
        step_chk(1, 3);
        for (int i = 0; i < 12; i++) begin
            step_chk(0, 0);
            if (int'(cur_div) == 6) chk("never_six", int'(cur_div), 3);
        end

        // N=2 and the maximum ratio.
        step_chk(1, 2);
        for (int i = 0; i < 10; i++) step_chk(0, 0);
        step_chk(1, 255);
        for (int i = 0; i < 520; i++) step_chk(0, 0);

        // Reset mid high phase with 8 pending.
        step_chk(1, 4);
        begin
            int guard = 0;
            while (!rise_stb && guard < 600) begin
                step_chk(0, 0);
                guard++;
            end
            chk("rise_seen", int'(rise_stb), 1);
        end
        step_chk(1, 8);
        chk("pre_rst_busy", int'(div_busy), 1);
        chk("pre_rst_clk",  int'(clk_out),  1);
        apply_reset();
        for (int i = 0; i < 8; i++) step_chk(0, 0);

        // Randomized loads and occasional async resets.
        for (int i = 0; i < 4000; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 6) begin
                int v;
                case ($urandom_range(0, 5))
                    0:       v = int'($urandom_range(0, 1));
                    1:       v = 255;
                    default: v = int'($urandom_range(2, 12));
                endcase
                step_chk(1, v);
            end else if (r == 99 && ($urandom_range(0, 9) == 0)) begin
                apply_reset();
            end else begin
                step_chk(0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
- Programmable integer clock divider that generates the divided clocks consumed by the fixed divide-by-4 stage and its siblings.
- Replaces hard-wired ripple division where the ratio must change at run time.
- Fully synchronous to clk_in. No derived clocks are used internally, so it is glitch-free.
- Ratio changes are requested through a load/busy handshake and are applied only at an output-period boundary.

Parameters:
- CNT_W, 8: width of the divisor and of the internal counter. Maximum ratio is 2^CNT_W-1.
- DEFAULT_DIV, 4: ratio active after reset. Must be >= 2 and <= 2^CNT_W-1.

Ports:
- clk_in, input, 1: source clock. All logic is on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- div_val, input, CNT_W: requested divide ratio N. Sampled when div_load=1.
- div_load, input, 1: one-cycle request to adopt div_val.
- div_busy, output, 1: high while an accepted ratio is pending and not yet applied.
- div_err, output, 1: one-cycle pulse when a load carries an illegal ratio (N<2).
- clk_out, output, 1: divided clock, driven directly from a register.
- rise_stb, output, 1: one-cycle strobe, high in the first clk_in cycle of each clk_out high phase.
- cur_div, output, CNT_W: ratio currently in effect.

Behaviour:

Registers:
- cnt (CNT_W), cur_div, shadow (CNT_W), pend, clk_out, rise_stb, div_err.

Reset values (applied on reset_n low, asynchronously):
- cnt = DEFAULT_DIV-1
- cur_div = DEFAULT_DIV
- shadow = DEFAULT_DIV
- pend = 0, so div_busy = 0
- clk_out = 0, rise_stb = 0, div_err = 0

Counting, per clk_in rising edge:
- wrap = (cnt == cur_div-1).
- cnt_next = wrap ? 0 : cnt+1.
- On a wrap edge with pend=1: cur_div <= shadow, pend <= 0, and the high-phase length H for this edge is taken from shadow.
- H = ceil(N/2).
- clk_out <= (cnt_next < H).
- rise_stb <= (cnt_next == 0).

Resulting waveform:
- Period is N clk_in cycles.
- High phase is ceil(N/2) cycles and low phase is floor(N/2) cycles. Even N gives 50% duty; odd N gives one extra high cycle.
- The first clk_in edge after reset release wraps the counter. clk_out rises on that edge, so latency from reset release to the first rise is 1 edge.

Handshake and state machine:
- Two states: RUN (pend=0) and PEND (pend=1). div_busy = pend.
- RUN, div_load=1, div_val>=2: shadow <= div_val, move to PEND. div_busy is visible the next cycle.
- Any state, div_load=1, div_val<2: request ignored, div_err=1 for exactly one cycle, state unchanged.
- PEND, div_load=1, div_val>=2: shadow is overwritten (last write wins). Remains in PEND.
- PEND, wrap edge: apply the ratio as described above and return to RUN. If div_load=1 on that same edge with a legal value, shadow takes the new value and the state stays in PEND for the following boundary.
- A load that lands on a wrap edge while in RUN is not applied on that edge. It is applied at the next boundary.
- The period in progress always completes with the old ratio. The new ratio never truncates or stretches a phase.
- cur_div changes only on wrap edges.

Boundary cases:
- N = 2^CNT_W-1: cnt reaches its maximum value without overflow.
- N = 2: clk_out toggles every clk_in cycle, and rise_stb fires every 2 cycles.
- Reset asserted mid-operation: immediate return to the reset values, and any pending ratio is discarded.

Test Plan:
- Release reset, no loads -> clk_out sequence 1,1,0,0 repeating; rise_stb every 4th cycle, aligned with the first high cycle; cur_div=4; div_busy=0.
- Load N=6 one cycle after a rising strobe -> div_busy=1; the remaining /4 period completes (2 low cycles after the high phase); next period is 3 high then 3 low; cur_div=6 from the boundary edge; div_busy clears on that edge.
- Load N=5 -> after the boundary, 3 high and 2 low per period; rise_stb spacing is 5 cycles.
- Load N=1, then N=0 -> div_err pulses for one cycle each; cur_div, div_busy and waveform are unchanged.
- While in PEND with N=6, load N=3 before the boundary -> boundary applies 3 (2 high, 1 low); 6 is never applied.
- Drop reset_n mid high-phase with N=8 pending -> clk_out=0, div_busy=0, cur_div=4 immediately; after release, clk_out rises on the first edge and follows the /4 waveform.
